// File: rtl/ddr3_req_arbiter.sv
// Two-port round-robin request arbiter / sequencer for the DDR3 MIG app_* interface.
// Ports: ui_clk / ui_clk_sync_rst (async, active high) and init_calib_complete.
//   req0_* / req1_*       : client requests (valid/ready, write, addr, wdata, wmask).
//   rsp0_* / rsp1_*       : read data returned to the port that issued the read.
//   app_*                 : MIG user command, write-data and read-data channels.
//   err_rd_underflow      : sticky flag, read data arrived with no outstanding read.
module ddr3_req_arbiter #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 512,
  parameter int MASK_WIDTH = 64,
  parameter int RD_DEPTH   = 16
) (
  input  logic                  ui_clk,
  input  logic                  ui_clk_sync_rst,
  input  logic                  init_calib_complete,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [MASK_WIDTH-1:0] req0_wmask,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [MASK_WIDTH-1:0] req1_wmask,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [DATA_WIDTH-1:0] app_wdf_data,
  output logic [MASK_WIDTH-1:0] app_wdf_mask,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0] app_rd_data,
  input  logic                  app_rd_data_valid,
  output logic                  err_rd_underflow
);

  localparam int PW = $clog2(RD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RD_DEPTH);

  localparam logic [1:0] S_WAIT_CAL = 2'd0;
  localparam logic [1:0] S_ARB      = 2'd1;
  localparam logic [1:0] S_WR       = 2'd2;
  localparam logic [1:0] S_RD       = 2'd3;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  logic [1:0]            state;
  logic                  rr;
  logic                  gnt_port;
  logic [RD_DEPTH-1:0]   tag_mem;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         tag_cnt;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic rd_ok;
  logic elig0;
  logic elig1;
  logic gnt0;
  logic gnt1;
  logic sel_write;
  logic en_hs;
  logic wdf_hs;
  logic push;
  logic pop;
  logic fifo_empty;

  // Reads are held back once every tag slot is in use; writes never are.
  assign rd_ok = tag_cnt < DEPTH_C;
  assign elig0 = req0_valid & (req0_write | rd_ok);
  assign elig1 = req1_valid & (req1_write | rd_ok);

  // rr = 0 prefers port 0 when both are eligible.
  assign gnt0 = (state == S_ARB) & elig0 & (~elig1 | ~rr);
  assign gnt1 = (state == S_ARB) & elig1 & (~elig0 | rr);

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign sel_write = gnt1 ? req1_write : req0_write;

  assign en_hs  = app_en & app_rdy;
  assign wdf_hs = app_wdf_wren & app_wdf_rdy;

  assign fifo_empty = (tag_cnt == '0);
  assign push = (state == S_RD) & en_hs;
  assign pop  = app_rd_data_valid & ~fifo_empty;

  assign app_wdf_end = app_wdf_wren;

  assign rsp0_data = rd_data_q;
  assign rsp1_data = rd_data_q;

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      state        <= S_WAIT_CAL;
      rr           <= 1'b0;
      gnt_port     <= 1'b0;
      app_en       <= 1'b0;
      app_cmd      <= 3'b000;
      app_addr     <= '0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      app_wdf_wren <= 1'b0;
    end else begin
      unique case (state)
        S_WAIT_CAL: begin
          if (init_calib_complete) state <= S_ARB;
        end
        S_ARB: begin
          if (gnt0 | gnt1) begin
            rr           <= gnt0;
            gnt_port     <= gnt1;
            app_en       <= 1'b1;
            app_wdf_wren <= sel_write;
            app_cmd      <= sel_write ? CMD_WR : CMD_RD;
            app_addr     <= gnt1 ? req1_addr : req0_addr;
            app_wdf_data <= gnt1 ? req1_wdata : req0_wdata;
            app_wdf_mask <= gnt1 ? req1_wmask : req0_wmask;
            state        <= sel_write ? S_WR : S_RD;
          end
        end
        S_WR: begin
          // Command and data handshakes retire independently.
          if (en_hs) app_en <= 1'b0;
          if (wdf_hs) app_wdf_wren <= 1'b0;
          if ((~app_en | app_rdy) & (~app_wdf_wren | app_wdf_rdy))
            state <= S_ARB;
        end
        S_RD: begin
          if (app_rdy) begin
            app_en <= 1'b0;
            state  <= S_ARB;
          end
        end
        default: state <= S_WAIT_CAL;
      endcase
    end
  end

  // In-order tag FIFO: one bit per outstanding read naming its port.
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= gnt_port;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push & ~pop) tag_cnt <= tag_cnt + CW'(1);
      else if (pop & ~push) tag_cnt <= tag_cnt - CW'(1);
    end
  end

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      rsp0_valid       <= 1'b0;
      rsp1_valid       <= 1'b0;
      rd_data_q        <= '0;
      err_rd_underflow <= 1'b0;
    end else begin
      rsp0_valid <= pop & ~tag_mem[rd_ptr];
      rsp1_valid <= pop & tag_mem[rd_ptr];
      if (pop) rd_data_q <= app_rd_data;
      if (app_rd_data_valid & fifo_empty) err_rd_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Scoreboard bench for ddr3_req_arbiter: queued client drivers, a MIG model
// driven from directed steps, and a monitor that checks every app/rsp event.
module tb_ddr3_req_arbiter;

  typedef struct {
    logic         wr;
    logic [29:0]  addr;
    logic [511:0] data;
    logic [63:0]  mask;
  } req_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         calib;
  logic         req0_valid, req0_ready, req0_write;
  logic [29:0]  req0_addr;
  logic [511:0] req0_wdata;
  logic [63:0]  req0_wmask;
  logic         req1_valid, req1_ready, req1_write;
  logic [29:0]  req1_addr;
  logic [511:0] req1_wdata;
  logic [63:0]  req1_wmask;
  logic         rsp0_valid, rsp1_valid;
  logic [511:0] rsp0_data, rsp1_data;
  logic [29:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy;
  logic [511:0] app_wdf_data;
  logic [63:0]  app_wdf_mask;
  logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [511:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         err;

  req_t         q0[$];
  req_t         q1[$];
  logic [32:0]  cmd_q[$];
  logic [575:0] wd_q[$];
  logic [512:0] rsp_q[$];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ddr3_req_arbiter dut (
    .ui_clk(clk),
    .ui_clk_sync_rst(rst),
    .init_calib_complete(calib),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_write(req0_write),
    .req0_addr(req0_addr),
    .req0_wdata(req0_wdata),
    .req0_wmask(req0_wmask),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_write(req1_write),
    .req1_addr(req1_addr),
    .req1_wdata(req1_wdata),
    .req1_wmask(req1_wmask),
    .rsp0_valid(rsp0_valid),
    .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid),
    .rsp1_data(rsp1_data),
    .app_addr(app_addr),
    .app_cmd(app_cmd),
    .app_en(app_en),
    .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid),
    .err_rd_underflow(err)
  );

  task automatic check(input string name,
                       input logic [575:0] act,
                       input logic [575:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_word(input logic port, input logic [511:0] d);
    app_rd_data = d;
    app_rd_data_valid = 1'b1;
    rsp_q.push_back({port, d});
    tick();
    app_rd_data_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic idle;
    int n;
    idle = 1'b0;
    n = 0;
    while (!idle && n < 200) begin
      @(negedge clk);
      idle = (q0.size() == 0) && (q1.size() == 0) &&
             !app_en && !app_wdf_wren;
      n++;
    end
    check(name, 576'(idle), 576'(1));
    tick();
  endtask

  // Client drivers: present queue heads, retire them on valid&ready.
  initial begin : drv
    logic a0, a1;
    req0_valid = 0; req0_write = 0; req0_addr = '0;
    req0_wdata = '0; req0_wmask = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0;
    req1_wdata = '0; req1_wmask = '0;
    forever begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #2;
      if (a0 && q0.size() != 0) q0.delete(0);
      if (a1 && q1.size() != 0) q1.delete(0);
      req0_valid = q0.size() != 0;
      if (q0.size() != 0) begin
        req0_write = q0[0].wr; req0_addr = q0[0].addr;
        req0_wdata = q0[0].data; req0_wmask = q0[0].mask;
      end
      req1_valid = q1.size() != 0;
      if (q1.size() != 0) begin
        req1_write = q1[0].wr; req1_addr = q1[0].addr;
        req1_wdata = q1[0].data; req1_wmask = q1[0].mask;
      end
    end
  end

  // Monitor: every MIG handshake and every response pops the scoreboard.
  initial begin : mon
    logic [32:0]  ec;
    logic [575:0] ew;
    logic [512:0] er;
    logic         rdv_prev;
    rdv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("ready_onehot", 576'(req0_ready & req1_ready), 576'(0));
        check("wdf_end", 576'(app_wdf_end), 576'(app_wdf_wren));
        if (app_en && app_rdy) begin
          check("cmd_expected", 576'(cmd_q.size() != 0), 576'(1));
          if (cmd_q.size() != 0) begin
            ec = cmd_q.pop_front();
            check("cmd_addr", 576'({app_cmd, app_addr}), 576'(ec));
          end
        end
        if (app_wdf_wren && app_wdf_rdy) begin
          check("wdf_expected", 576'(wd_q.size() != 0), 576'(1));
          if (wd_q.size() != 0) begin
            ew = wd_q.pop_front();
            check("wdf_data_mask", {app_wdf_data, app_wdf_mask}, ew);
          end
        end
        if (rsp0_valid || rsp1_valid) begin
          check("rsp_latency", 576'(rdv_prev), 576'(1));
          check("rsp_expected", 576'(rsp_q.size() != 0), 576'(1));
          if (rsp_q.size() != 0) begin
            er = rsp_q.pop_front();
            check("rsp_port", 576'({rsp1_valid, rsp0_valid}),
                  576'(er[512] ? 2'b10 : 2'b01));
            check("rsp_data", 576'(er[512] ? rsp1_data : rsp0_data),
                  576'(er[511:0]));
          end
        end
      end
      rdv_prev = app_rd_data_valid;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst = 1'b1;
    calib = 1'b0;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    app_rd_data = '0;
    app_rd_data_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_app_en", 576'(app_en), 576'(0));
    check("rst_cmd_addr", 576'({app_cmd, app_addr}), 576'(0));
    check("rst_wdf", 576'({app_wdf_wren, app_wdf_end, app_wdf_mask}),
          576'(0));
    check("rst_wdf_data", 576'(app_wdf_data), 576'(0));
    check("rst_ready", 576'({req1_ready, req0_ready}), 576'(0));
    check("rst_rsp", 576'({rsp1_valid, rsp0_valid}), 576'(0));
    check("rst_rsp_data", 576'(rsp0_data | rsp1_data), 576'(0));
    check("rst_err", 576'(err), 576'(0));

    // Calibration gate with a pending write on port 0.
    tick();
    rst = 1'b0;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b0;
    q0.push_back('{1'b1, 30'h100, {64{8'hA5}}, 64'h0});
    cmd_q.push_back({3'b000, 30'h100});
    wd_q.push_back({{64{8'hA5}}, 64'h0});
    repeat (4) begin
      @(negedge clk);
      check("nocal_ready", 576'(req0_ready), 576'(0));
      check("nocal_app_en", 576'(app_en), 576'(0));
    end
    tick();
    calib = 1'b1;
    @(negedge clk);
    check("cal_ready_same", 576'(req0_ready), 576'(0));
    @(negedge clk);
    check("cal_ready_next", 576'(req0_ready), 576'(1));

    // Single write, write-data ready delayed 3 cycles.
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 2) begin
        q1.push_back('{1'b0, 30'h200, '0, '0});
        cmd_q.push_back({3'b001, 30'h200});
      end
      if (k == 4) app_wdf_rdy = 1'b1;
      @(negedge clk);
      check("wr_wren_held", 576'(app_wdf_wren), 576'(1));
      check("wr_app_en", 576'(app_en), 576'(k == 1));
      check("wr_no_grant", 576'(req1_ready), 576'(0));
    end
    tick();
    @(negedge clk);
    check("wr_wren_drop", 576'(app_wdf_wren), 576'(0));
    check("arb_after_wr", 576'(req1_ready), 576'(1));
    tick();
    wait_idle("single_rd_drain");
    rd_word(1'b1, {16{32'hD0D0_0001}});

    // Contention: both ports stream reads, grants alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b0, 30'(32'h1000 + i), '0, '0});
      q1.push_back('{1'b0, 30'(32'h2000 + i), '0, '0});
      cmd_q.push_back({3'b001, 30'(32'h1000 + i)});
      cmd_q.push_back({3'b001, 30'(32'h2000 + i)});
    end
    wait_idle("contention_drain");
    for (int i = 0; i < 8; i++)
      rd_word(1'(i % 2), {16{32'(32'hC0DE_0000 + i)}});
    tick();
    tick();

    // MIG stall during a read.
    app_rdy = 1'b0;
    q0.push_back('{1'b0, 30'h3000, '0, '0});
    cmd_q.push_back({3'b001, 30'h3000});
    for (int n = 0; n < 20 && !app_en; n++) @(negedge clk);
    check("stall_en_seen", 576'(app_en), 576'(1));
    repeat (5) begin
      tick();
      @(negedge clk);
      check("stall_en_held", 576'(app_en), 576'(1));
      check("stall_cmd_addr", 576'({app_cmd, app_addr}),
            576'({3'b001, 30'h3000}));
    end
    tick();
    app_rdy = 1'b1;
    @(negedge clk);
    check("stall_release", 576'(app_en), 576'(1));
    tick();
    @(negedge clk);
    check("stall_en_drop", 576'(app_en), 576'(0));
    tick();
    rd_word(1'b0, {16{32'h5717_0000}});
    tick();
    @(negedge clk);
    check("err_before_uf", 576'(err), 576'(0));

    // Underflow: the single stall tag is consumed, so this word is unmatched.
    tick();
    app_rd_data = {16{32'hBAD0_BAD0}};
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    @(negedge clk);
    check("uf_no_rsp", 576'({rsp1_valid, rsp0_valid}), 576'(0));
    check("uf_err_set", 576'(err), 576'(1));
    repeat (5) tick();
    @(negedge clk);
    check("uf_err_sticky", 576'(err), 576'(1));
    tick();

    // Outstanding limit: 16 reads fill the tag FIFO.
    for (int i = 0; i < 16; i++) begin
      q0.push_back('{1'b0, 30'(32'h4000 + i), '0, '0});
      cmd_q.push_back({3'b001, 30'(32'h4000 + i)});
    end
    wait_idle("limit_fill");
    q0.push_back('{1'b0, 30'h4010, '0, '0});
    q1.push_back('{1'b1, 30'h5000, {16{32'h5A5A_0001}}, 64'hF0});
    cmd_q.push_back({3'b000, 30'h5000});
    wd_q.push_back({{16{32'h5A5A_0001}}, 64'hF0});
    repeat (8) begin
      @(negedge clk);
      check("limit_no_rd17", 576'(req0_ready), 576'(0));
      tick();
    end
    check("limit_wr_granted", 576'(q1.size()), 576'(0));
    cmd_q.push_back({3'b001, 30'h4010});
    rd_word(1'b0, {16{32'h1111_0000}});
    wait_idle("limit_rd17");
    for (int i = 0; i < 16; i++)
      rd_word(1'b0, {16{32'(32'h2222_0000 + i)}});
    repeat (3) tick();

    check("cmd_q_empty", 576'(cmd_q.size()), 576'(0));
    check("wd_q_empty", 576'(wd_q.size()), 576'(0));
    check("rsp_q_empty", 576'(rsp_q.size()), 576'(0));

    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst2_err", 576'(err), 576'(0));
    check("rst2_app_en", 576'(app_en), 576'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
